// File: rtl/alu_share_pkg.sv
// Shared types for the ALU share arbiter: FSM states, default widths and
// the default-width operation slot layout.
package alu_share_pkg;

    localparam int DW_DEF = 32;
    localparam int CW_DEF = 2;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // Operation slot at default widths; the top re-declares it at its own widths.
    typedef struct packed {
        logic [DW_DEF-1:0] srcA;
        logic [DW_DEF-1:0] srcB;
        logic [CW_DEF-1:0] ctrl;
    } op_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. The search starts one past ptr and wraps,
// so the last winner ends up with the lowest priority. The pointer register
// lives in the parent.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx
);

    logic [IW-1:0] cand;
    logic          found;

    // Walk ptr+1 .. ptr+NREQ (mod NREQ) and take the first requester that is set.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(ptr) + k) % NREQ);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one combinational ALU between NREQ requesters. A request is
// latched into an op register, the ALU is driven from that register for one
// cycle, and the result is held until the owning requester takes it.
// Optional per-requester grant counters: define ALU_SHARE_STATS_EN.
module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int DW   = DW_DEF,
    parameter int CW   = CW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*DW-1:0]   req_srcA,
    input  logic [NREQ*DW-1:0]   req_srcB,
    input  logic [NREQ*CW-1:0]   req_ctrl,
    output logic [DW-1:0]        alu_srcA,
    output logic [DW-1:0]        alu_srcB,
    output logic [CW-1:0]        alu_ctrl,
    input  logic [DW-1:0]        alu_out,
    input  logic                 alu_zero,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [DW-1:0]        rsp_data,
    output logic                 rsp_zero
`ifdef ALU_SHARE_STATS_EN
    ,
    output logic [NREQ*CNT_W-1:0] grant_cnt
`endif
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef struct packed {
        logic [DW-1:0] srcA;
        logic [DW-1:0] srcB;
        logic [CW-1:0] ctrl;
    } aluOp_t;

    state_t          stateReg, stateNext;
    aluOp_t          opReg;
    logic [IW-1:0]   ownerReg;
    logic [IW-1:0]   rrPtrReg;
    logic [DW-1:0]   rspDataReg;
    logic            rspZeroReg;

    logic [NREQ-1:0] grantVec;
    logic [IW-1:0]   grantIdx;
    logic            anyReq;
    logic            acceptEn;

    logic [DW-1:0]   srcAArr [NREQ];
    logic [DW-1:0]   srcBArr [NREQ];
    logic [CW-1:0]   ctrlArr [NREQ];

    // Unpack the flat request buses so the winner can be picked by index.
    for (genvar gi = 0; gi < NREQ; gi++) begin : gUnpack
        assign srcAArr[gi] = req_srcA[gi*DW +: DW];
        assign srcBArr[gi] = req_srcB[gi*DW +: DW];
        assign ctrlArr[gi] = req_ctrl[gi*CW +: CW];
    end

    assign anyReq = |req_valid;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) uArb (
        .req   (req_valid),
        .ptr   (rrPtrReg),
        .grant (grantVec),
        .idx   (grantIdx)
    );

    // Next state and request handshake; a result handshake may overlap a new accept.
    always_comb begin
        stateNext = stateReg;
        req_ready = '0;
        acceptEn  = 1'b0;
        case (stateReg)
            IDLE: begin
                req_ready = grantVec;
                if (anyReq) begin
                    acceptEn  = 1'b1;
                    stateNext = ISSUE;
                end
            end
            ISSUE: begin
                stateNext = RESP;
            end
            RESP: begin
                if (rsp_ready[ownerReg]) begin
                    if (anyReq) begin
                        req_ready = grantVec;
                        acceptEn  = 1'b1;
                        stateNext = ISSUE;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Result valid is decoded from state so reset clears it without waiting for a clock.
    always_comb begin
        rsp_valid = '0;
        if (stateReg == RESP) begin
            rsp_valid[ownerReg] = 1'b1;
        end
    end

    // State, op slot, owner/pointer and result buffer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg   <= IDLE;
            opReg      <= '0;
            ownerReg   <= '0;
            rrPtrReg   <= IW'(NREQ - 1);
            rspDataReg <= '0;
            rspZeroReg <= 1'b0;
        end else begin
            stateReg <= stateNext;
            if (acceptEn) begin
                opReg.srcA <= srcAArr[grantIdx];
                opReg.srcB <= srcBArr[grantIdx];
                opReg.ctrl <= ctrlArr[grantIdx];
                ownerReg   <= grantIdx;
                rrPtrReg   <= grantIdx;
            end
            if (stateReg == ISSUE) begin
                rspDataReg <= alu_out;
                rspZeroReg <= alu_zero;
            end
        end
    end

    // The ALU sees only the op register, so its inputs move only at an accept.
    assign alu_srcA = opReg.srcA;
    assign alu_srcB = opReg.srcB;
    assign alu_ctrl = opReg.ctrl;
    assign rsp_data = rspDataReg;
    assign rsp_zero = rspZeroReg;

`ifdef ALU_SHARE_STATS_EN
    logic [CNT_W-1:0] grantCntReg [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : gStats
        // Saturating count of accepts for requester gi.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                grantCntReg[gi] <= '0;
            end else if (req_valid[gi] && req_ready[gi] && (grantCntReg[gi] != {CNT_W{1'b1}})) begin
                grantCntReg[gi] <= grantCntReg[gi] + 1'b1;
            end
        end
        assign grant_cnt[gi*CNT_W +: CNT_W] = grantCntReg[gi];
    end
`endif

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares the single execute-stage ALU (32-bit srcA/srcB, 2-bit ctrl, result plus zero flag) between NREQ requesters, e.g. the main pipeline and a branch-target unit. It arbitrates requests round-robin, drives the ALU operands from a registered operation slot, and buffers one result until the owning requester accepts it. It sits between the requesters and the execute module; the ALU itself stays purely combinational.

Parameters:
NREQ, 2, number of requesters (2..8)
DW, 32, operand/result width
CW, 2, ALU ctrl width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  NREQ  request valid, one bit per requester
req_ready  out  NREQ  request accepted this cycle when valid&ready
req_srcA  in  NREQ*DW  operand A, requester i at [i*DW +: DW]
req_srcB  in  NREQ*DW  operand B, same packing
req_ctrl  in  NREQ*CW  ALU op, requester i at [i*CW +: CW]
alu_srcA  out  DW  to ALU aluSrcA
alu_srcB  out  DW  to ALU aluSrcB
alu_ctrl  out  CW  to ALU ctrl
alu_out  in  DW  from ALU EXaluOut
alu_zero  in  1  from ALU ALUzeroOp
rsp_valid  out  NREQ  result valid, one-hot to owner
rsp_ready  in  NREQ  requester accepts result
rsp_data  out  DW  buffered ALU result
rsp_zero  out  1  buffered zero flag

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, rsp_valid=0, rsp_data=0, rsp_zero=0, alu_srcA/B=0, alu_ctrl=0, owner=0, rr_ptr=NREQ-1 (requester 0 wins first).
- States: IDLE, ISSUE, RESP.
- IDLE: req_ready=grant vector (one-hot, round-robin starting at rr_ptr+1). If any req_valid, latch the winner's operands/ctrl into the op register, set owner and rr_ptr to the winner, and go to ISSUE. Otherwise stay.
- ISSUE (1 cycle): alu_* are driven from the op register (registered outputs). At the clock edge, capture alu_out/alu_zero into rsp_data/rsp_zero and go to RESP. req_ready=0.
- RESP: rsp_valid[owner]=1, other bits 0. rsp_data/rsp_zero are held stable until rsp_ready[owner]. rsp_ready bits of non-owners are ignored.
  - On the handshake with any req_valid: same-cycle back-to-back accept. req_ready=grant, go to ISSUE.
  - On the handshake with no req_valid: go to IDLE.
  - Without the handshake: stay. req_ready=0.
- Latency: accept at edge N, ALU driven in cycle N+1, rsp_valid high in cycle N+2. Peak throughput is 1 op per 2 cycles.
- alu_* hold the last op-register value outside ISSUE; there are no spurious changes.
- A requester dropping req_valid without a handshake is legal and loses nothing. Operands are sampled only at the accept edge.
- Round-robin: after granting i, priority order is i+1 … NREQ-1, 0 … i. A lone requester may be granted every time.
- Reset asserted in ISSUE/RESP: the pending result is discarded, rsp_valid drops asynchronously, and there is no response after reset release.
- At most one req_ready bit and one rsp_valid bit are high in any cycle.

Optional Feature:
Macro ALU_SHARE_STATS_EN.
- Defined: adds output grant_cnt (NREQ*16). Per-requester counter increments on each accept, saturates at 16'hFFFF, and resets to 0 on rst.
- Undefined: the port and the counters are absent. Core behaviour is identical.

Decomposition:
- Package alu_share_pkg: state enum (IDLE/ISSUE/RESP), DW/CW default localparams, op struct {srcA, srcB, ctrl}.
- Sub-module rr_arbiter: NREQ, inputs req/ptr, outputs one-hot grant and index. It is combinational; the pointer lives in the parent.

Test Plan:
- Bench ALU model returns A+B. Single request: req0 A=5, B=7, ctrl=2'b00 → rsp_valid[0] exactly 2 cycles after accept, rsp_data=12, rsp_zero=0.
- Zero flag: req1 A=32'hFFFF_FFFF, B=1 → rsp_data=0, rsp_zero=1, rsp_valid=2'b10.
- Contention: req0 and req1 held valid from reset with rsp_ready=1 → grant order 0,1,0,1. Each accepts once per 2 cycles and no requester is starved.
- Backpressure: rsp_ready[0]=0 for 5 cycles → rsp_data stable, req_ready=0, alu_* unchanged. When rsp_ready rises with req1 pending, req1 is accepted the same cycle.
- Reset mid-op: assert rst in ISSUE → all outputs 0 immediately. After release there is no rsp_valid, and the next grant goes to requester 0.
- With ALU_SHARE_STATS_EN: 70000 accepts on req0 → grant_cnt[0]=16'hFFFF (saturated), grant_cnt[1]=0.
